// File: rtl/cmlk_3d_pkg.sv
// Shared constants for the 3D image framer: header magic, FIFO entry layout
// and output FSM state encoding.
package cmlk_3d_pkg;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;

   localparam int DATA_W  = 32;
   localparam int EOL_BIT = 32;
   localparam int SOL_BIT = 33;
   localparam int SOF_BIT = 34;
   localparam int ENTRY_W = 35;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

endpackage

// File: rtl/cmlk_3d_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output and a
// look-ahead port showing the entry that becomes the head after one pop.
module cmlk_3d_sync_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 512
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [WIDTH-1:0]         dout_next,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW-1:0]    rd_idx_next;
   logic             push_ok;
   logic             pop_ok;

   assign level       = wr_ptr - rd_ptr;
   assign full        = level[AW];
   assign empty       = (level == '0);
   assign pop_ok      = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok     = push && (!full || pop_ok);
   assign rd_idx_next = rd_ptr[AW-1:0] + AW'(1);
   assign dout        = mem[rd_ptr[AW-1:0]];
   assign dout_next   = (level > (AW+1)'(1)) ? mem[rd_idx_next] : din;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/cmlk_3d_img_framer.sv
// Line/frame framer for the 32-bit repacker stream with an AXI4-Stream master
// output. Define CMLK_3D_LINE_HDR_EN to emit a header beat ahead of every line.
module cmlk_3d_img_framer
   import cmlk_3d_pkg::*;
#(
   parameter int WORDS_PER_LINE  = 256,
   parameter int LINES_PER_FRAME = 64,
   parameter int FIFO_DEPTH      = 512
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [31:0]                   din,
   input  logic                          din_vld,
   input  logic                          frame_sync,
   output logic [31:0]                   m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int WCNT_W = $clog2(WORDS_PER_LINE);
   localparam int LCNT_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

   state_t              state;
   state_t              state_nxt;
   logic [WCNT_W-1:0]   wcnt;
   logic [WCNT_W-1:0]   wcnt_eff;
   logic [LCNT_W-1:0]   lcnt;
   logic [LCNT_W-1:0]   lcnt_eff;
   logic                discard;
   logic                want;
   logic                push;
   logic                drop;
   logic                pop;
   logic                last_w;
   logic                last_l;
   logic [ENTRY_W-1:0]  wr_entry;
   logic [ENTRY_W-1:0]  head;
   logic [ENTRY_W-1:0]  head_next;
   logic                fifo_full;
   logic                fifo_empty;
   logic                head_hdr;
   logic                next_hdr;
   logic                unused_bits;

   // frame_sync realigns the very word that arrives with it.
   assign wcnt_eff = frame_sync ? '0 : wcnt;
   assign lcnt_eff = frame_sync ? '0 : lcnt;
   assign last_w   = (wcnt_eff == WCNT_W'(WORDS_PER_LINE - 1));
   assign last_l   = (lcnt_eff == LCNT_W'(LINES_PER_FRAME - 1));
   assign want     = din_vld && !(discard && !frame_sync);
   assign push     = want && (!fifo_full || pop);
   assign drop     = want && fifo_full && !pop;

   always_comb begin
      wr_entry                 = '0;
      wr_entry[DATA_W-1:0]     = din;
      wr_entry[EOL_BIT]        = last_w;
      wr_entry[SOL_BIT]        = (wcnt_eff == '0);
      wr_entry[SOF_BIT]        = (wcnt_eff == '0) && (lcnt_eff == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt     <= '0;
         lcnt     <= '0;
         discard  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            if (last_w) begin
               wcnt <= '0;
               lcnt <= last_l ? '0 : lcnt_eff + LCNT_W'(1);
            end else begin
               wcnt <= wcnt_eff + WCNT_W'(1);
               lcnt <= lcnt_eff;
            end
         end else if (frame_sync) begin
            wcnt <= '0;
            lcnt <= '0;
         end
         if (drop) begin
            overflow <= 1'b1;
            discard  <= 1'b1;
         end else if (frame_sync) begin
            discard  <= 1'b0;
         end
      end
   end

   cmlk_3d_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .din       (wr_entry),
      .pop       (pop),
      .dout      (head),
      .dout_next (head_next),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

`ifdef CMLK_3D_LINE_HDR_EN
   logic [7:0]  frame_cnt;
   logic [7:0]  cur_frame;
   logic [15:0] line_cnt;

   assign head_hdr = head[SOL_BIT];
   assign next_hdr = head_next[SOL_BIT];

   // frame_cnt counts frames started; cur_frame is the number stamped on later lines.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         cur_frame <= '0;
         line_cnt  <= '0;
      end else if (state == ST_HDR && m_axis_tready) begin
         if (head[SOF_BIT]) begin
            frame_cnt <= frame_cnt + 8'd1;
            cur_frame <= frame_cnt;
            line_cnt  <= 16'd1;
         end else begin
            line_cnt  <= line_cnt + 16'd1;
         end
      end
   end
`else
   assign head_hdr = 1'b0;
   assign next_hdr = 1'b0;
`endif

   assign unused_bits = ^{head_next, head[SOL_BIT]};

   // AXI handshake: a beat transfers on a rising clk edge with tvalid && tready;
   // while tvalid is high the head entry and header counters cannot change, so
   // tdata/tlast/tuser hold until that transfer.
   assign pop = (state == ST_DATA) && m_axis_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_nxt = head_hdr ? ST_HDR : ST_DATA;
            end
         end
`ifdef CMLK_3D_LINE_HDR_EN
         ST_HDR: begin
            if (m_axis_tready) begin
               state_nxt = ST_DATA;
            end
         end
`endif
         ST_DATA: begin
            if (m_axis_tready) begin
               if (fifo_level == ($clog2(FIFO_DEPTH)+1)'(1) && !push) begin
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = next_hdr ? ST_HDR : ST_DATA;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      case (state)
`ifdef CMLK_3D_LINE_HDR_EN
         ST_HDR: begin
            m_axis_tvalid = 1'b1;
            m_axis_tuser  = head[SOF_BIT];
            m_axis_tdata  = head[SOF_BIT] ? {HDR_MAGIC, frame_cnt, 16'd0}
                                          : {HDR_MAGIC, cur_frame, line_cnt};
         end
         ST_DATA: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = head[DATA_W-1:0];
            m_axis_tlast  = head[EOL_BIT];
         end
`else
         ST_DATA: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = head[DATA_W-1:0];
            m_axis_tlast  = head[EOL_BIT];
            m_axis_tuser  = head[SOF_BIT];
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cmlk_3d_img_framer.sv
// Scoreboard bench for cmlk_3d_img_framer (4 words/line, 2 lines/frame, 4-deep FIFO);
// expected beats follow CMLK_3D_LINE_HDR_EN the same way the design does.
module tb_cmlk_3d_img_framer;

   localparam int W   = 34;
   localparam int WPL = 4;
   localparam int LPF = 2;
   localparam int FD  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] din = '0;
   logic        din_vld = 1'b0;
   logic        frame_sync = 1'b0;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        overflow;
   logic [2:0]  fifo_level;

   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           failures = 0;
   int           beat_cnt = 0;
   logic         bp_en = 1'b0;

   int           m_wcnt = 0;
   int           m_lcnt = 0;
   logic [7:0]   m_fcnt = '0;
   logic [7:0]   m_cur = '0;
   logic [15:0]  m_line = '0;

   cmlk_3d_img_framer #(
      .WORDS_PER_LINE  (WPL),
      .LINES_PER_FRAME (LPF),
      .FIFO_DEPTH      (FD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .din           (din),
      .din_vld       (din_vld),
      .frame_sync    (frame_sync),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .overflow      (overflow),
      .fifo_level    (fifo_level)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_wcnt = 0;
      m_lcnt = 0;
      m_fcnt = '0;
      m_cur  = '0;
      m_line = '0;
   endtask

   task automatic model_word(input logic [31:0] d, input logic sync);
      logic sof;
      logic eol;
      if (sync) begin
         m_wcnt = 0;
         m_lcnt = 0;
      end
      sof = (m_wcnt == 0) && (m_lcnt == 0);
      eol = (m_wcnt == WPL - 1);
`ifdef CMLK_3D_LINE_HDR_EN
      if (m_wcnt == 0) begin
         if (sof) begin
            exp_q.push_back({1'b1, 1'b0, 8'hA5, m_fcnt, 16'h0000});
            m_cur  = m_fcnt;
            m_fcnt = m_fcnt + 8'd1;
            m_line = 16'd1;
         end else begin
            exp_q.push_back({1'b0, 1'b0, 8'hA5, m_cur, m_line});
            m_line = m_line + 16'd1;
         end
      end
      exp_q.push_back({1'b0, eol, d});
`else
      exp_q.push_back({sof, eol, d});
`endif
      if (eol) begin
         m_wcnt = 0;
         m_lcnt = (m_lcnt == LPF - 1) ? 0 : m_lcnt + 1;
      end else begin
         m_wcnt = m_wcnt + 1;
      end
   endtask

   // driver tasks: entered and left at posedge + 1
   task automatic send(input logic [31:0] d, input logic sync, input logic acc);
      din        = d;
      din_vld    = 1'b1;
      frame_sync = sync;
      if (acc) begin
         model_word(d, sync);
      end
      @(posedge clk);
      #1;
      din_vld    = 1'b0;
      frame_sync = 1'b0;
      din        = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(tag, W'(exp_q.size()), W'(0));
      idle(4);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bp_en) begin
            m_axis_tready = !m_axis_tready;
         end
      end
   end

   // scoreboard monitor: samples mid-cycle, a beat completes at the next posedge
   initial begin
      logic [W-1:0] cur;
      logic [W-1:0] held;
      logic         stalled;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
         end else if (m_axis_tvalid) begin
            cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            if (stalled) begin
               check("hold", cur, held);
            end
            if (m_axis_tready) begin
               beat_cnt++;
               if (exp_q.size() == 0) begin
                  check("beat_unexpected_q", W'(exp_q.size()), W'(1));
               end else begin
                  check("beat", cur, exp_q.pop_front());
               end
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = cur;
            end
         end else begin
            if (stalled) begin
               check("hold_vld", W'(m_axis_tvalid), W'(1));
            end
            stalled = 1'b0;
         end
      end
   end

   initial begin
      int base;
      int n;

      // reset state
      @(posedge clk);
      #1;
      check("rst_tvalid", W'(m_axis_tvalid), W'(0));
      check("rst_tdata", W'(m_axis_tdata), W'(0));
      check("rst_tlast_tuser", W'({m_axis_tlast, m_axis_tuser}), W'(0));
      check("rst_overflow", W'(overflow), W'(0));
      check("rst_level", W'(fifo_level), W'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic frame, back to back
      m_axis_tready = 1'b1;
      for (int i = 0; i < 8; i++) send(32'(i), 1'b0, 1'b1);
      wait_drain("drain_basic");
      check("idle_tvalid", W'(m_axis_tvalid), W'(0));

      // second frame
      for (int i = 8; i < 16; i++) send(32'(i), 1'b0, 1'b1);
      wait_drain("drain_second");

      // backpressure with toggling tready
      bp_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send($urandom, 1'b0, 1'b1);
         idle($urandom_range(2, 4));
      end
      wait_drain("drain_bp");
      bp_en = 1'b0;
      m_axis_tready = 1'b1;
      check("no_overflow_yet", W'(overflow), W'(0));

      // overflow and recovery
      m_axis_tready = 1'b0;
      for (int i = 0; i < 6; i++) send(32'h100 + 32'(i), 1'b0, (i < 4) ? 1'b1 : 1'b0);
      idle(2);
      check("ovf_level", W'(fifo_level), W'(4));
      check("ovf_flag", W'(overflow), W'(1));
      send(32'h106, 1'b0, 1'b0);
      send(32'h107, 1'b0, 1'b0);
      check("ovf_level_hold", W'(fifo_level), W'(4));
      m_axis_tready = 1'b1;
      wait_drain("drain_old");
      send(32'h108, 1'b0, 1'b0);
      send(32'h109, 1'b0, 1'b0);
      idle(3);
      check("discard_level", W'(fifo_level), W'(0));
      send(32'h200, 1'b1, 1'b1);
      for (int i = 1; i < 4; i++) send(32'h200 + 32'(i), 1'b0, 1'b1);
      wait_drain("drain_recover");
      check("ovf_sticky", W'(overflow), W'(1));

      // reset in the middle of a line
      for (int i = 0; i < 4; i++) send(32'h300 + 32'(i), 1'b0, 1'b1);
      base = beat_cnt;
      n = 0;
      while (beat_cnt < base + 2 && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("rst_wait_beats", W'(beat_cnt - base), W'(2));
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", W'(m_axis_tvalid), W'(0));
      check("mid_rst_level", W'(fifo_level), W'(0));
      check("mid_rst_overflow", W'(overflow), W'(0));
      exp_q.delete();
      model_reset();
      idle(2);
      rst_n = 1'b1;
      idle(1);
      for (int i = 0; i < 4; i++) send(32'h400 + 32'(i), 1'b0, 1'b1);
      wait_drain("drain_after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
